// File: rtl/ttt_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ttt_pkg: shared widths, timeout default and state encodings for the job driver.
// Rev 1.0
// ----------------------------------------------------------------------------
package ttt_pkg;

  localparam int TTT_W       = 12;
  localparam int TTT_DEPTH   = 4;
  localparam int TTT_TIMEOUT = 255;
  localparam int TTT_TIMER_W = 8;

  // Responder state as seen on {Qd, Qc, Qi}
  typedef enum logic [2:0] {
    RSP_INI  = 3'b001,
    RSP_ADJ  = 3'b010,
    RSP_DONE = 3'b100
  } rsp_state_e;

  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_LAUNCH = 5'b00010,
    ST_WAIT   = 5'b00100,
    ST_ACK    = 5'b01000,
    ST_ERR    = 5'b10000
  } drv_state_e;

endpackage
`default_nettype wire

// File: rtl/ttt_job_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ttt_job_fifo: DEPTH-entry operand-pair queue with registered not-full/empty.
// Rev 1.0
// ----------------------------------------------------------------------------
module ttt_job_fifo
  import ttt_pkg::*;
#(
  parameter int W     = TTT_W,
  parameter int DEPTH = TTT_DEPTH
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         pop_i,
  output logic         not_full_o,
  output logic         empty_o,
  output logic [W-1:0] head_a_o,
  output logic [W-1:0] head_b_o
);

  // DEPTH is a power of two >= 2, so the pointers wrap by natural overflow
  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_a_q [DEPTH];
  logic [W-1:0]  mem_b_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          not_full_q, empty_q;
  logic          do_push, do_pop;

  assign do_push = push_i && not_full_q;
  assign do_pop  = pop_i && !empty_q;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_a_q[wr_ptr_q] <= a_i;
      mem_b_q[wr_ptr_q] <= b_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      not_full_q <= 1'b1;
      empty_q    <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      not_full_q <= (count_d != CNT_FULL);
      empty_q    <= (count_d == '0);
    end
  end

  assign not_full_o = not_full_q;
  assign empty_o    = empty_q;
  assign head_a_o   = mem_a_q[rd_ptr_q];
  assign head_b_o   = mem_b_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/ttt_job_driver.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ttt_job_driver: queues host jobs and runs them one at a time on an iterative
// responder via a Start/Ack handshake, with a timeout that parks in ERR.
// Rev 1.0
// ----------------------------------------------------------------------------
module ttt_job_driver
  import ttt_pkg::*;
#(
  parameter int W       = TTT_W,
  parameter int DEPTH   = TTT_DEPTH,
  parameter int TIMEOUT = TTT_TIMEOUT
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Req,
  input  logic [W-1:0] Ain_in,
  input  logic [W-1:0] Bin_in,
  output logic         Rdy,
  input  logic         Clear,
  output logic [W-1:0] Result,
  output logic         Result_valid,
  output logic         Err,
  output logic         Start,
  output logic         Ack,
  output logic [W-1:0] Ain,
  output logic [W-1:0] Bin,
  input  logic         Qi,
  input  logic         Qc,
  input  logic         Qd,
  input  logic [W-1:0] A
);

  localparam logic [TTT_TIMER_W-1:0] TMO = TTT_TIMER_W'(TIMEOUT);

  drv_state_e             state_q;
  logic [TTT_TIMER_W-1:0] timer_q;
  logic                   start_q, ack_q, rv_q, err_q;
  logic [W-1:0]           ain_q, bin_q, result_q;

  logic         w_empty, w_not_full, w_pop, w_ini, w_done;
  logic [W-1:0] w_head_a, w_head_b;

  assign w_ini  = ({Qd, Qc, Qi} == RSP_INI);
  assign w_done = ({Qd, Qc, Qi} == RSP_DONE);

  // The head leaves the queue only once the job completes or is discarded
  assign w_pop = (state_q == ST_WAIT) && (w_done || (timer_q == TMO));

  ttt_job_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i      (Clk),
    .rst_ni     (Reset),
    .push_i     (Req),
    .a_i        (Ain_in),
    .b_i        (Bin_in),
    .pop_i      (w_pop),
    .not_full_o (w_not_full),
    .empty_o    (w_empty),
    .head_a_o   (w_head_a),
    .head_b_o   (w_head_b)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      start_q  <= 1'b0;
      ack_q    <= 1'b0;
      rv_q     <= 1'b0;
      err_q    <= 1'b0;
      ain_q    <= '0;
      bin_q    <= '0;
      result_q <= '0;
    end else begin
      start_q <= 1'b0;
      rv_q    <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (!w_empty && w_ini) begin
            ain_q   <= w_head_a;
            bin_q   <= w_head_b;
            start_q <= 1'b1;
            state_q <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          timer_q <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          // Completion is checked first so it wins over a same-cycle timeout
          if (w_done) begin
            result_q <= A;
            rv_q     <= 1'b1;
            ack_q    <= 1'b1;
            state_q  <= ST_ACK;
          end else if (timer_q == TMO) begin
            err_q   <= 1'b1;
            state_q <= ST_ERR;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        ST_ACK: begin
          if (w_ini) begin
            ack_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_ERR: begin
          if (Clear) begin
            err_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign Rdy          = w_not_full;
  assign Start        = start_q;
  assign Ack          = ack_q;
  assign Result_valid = rv_q;
  assign Err          = err_q;
  assign Ain          = ain_q;
  assign Bin          = bin_q;
  assign Result       = result_q;

endmodule
`default_nettype wire

// File: tb/tb_ttt_job_driver.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_ttt_job_driver: bench with a behavioural responder and a queue model.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_ttt_job_driver;
  import ttt_pkg::*;

  localparam int W = 12;
  localparam int DEPTH = 4;

  logic         Clk = 1'b0;
  logic         Reset = 1'b0, Req = 1'b0, Clear = 1'b0;
  logic [W-1:0] Ain_in = '0, Bin_in = '0;
  logic         Rdy, Result_valid, Err, Start, Ack, Qi, Qc, Qd;
  logic [W-1:0] Result, Ain, Bin, A;

  always #5 Clk = ~Clk;

  ttt_job_driver #(.W(W), .DEPTH(DEPTH), .TIMEOUT(255)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .Ain_in(Ain_in), .Bin_in(Bin_in),
    .Rdy(Rdy), .Clear(Clear), .Result(Result), .Result_valid(Result_valid),
    .Err(Err), .Start(Start), .Ack(Ack), .Ain(Ain), .Bin(Bin),
    .Qi(Qi), .Qc(Qc), .Qd(Qd), .A(A)
  );

  // Behavioural responder: +100 while A<B (flag clear), -10 while A>B
  rsp_state_e   rs;
  logic [W-1:0] rb;
  logic         rflag, stall = 1'b0, kick = 1'b0;
  assign {Qd, Qc, Qi} = rs;

  always @(posedge Clk) begin
    if (!Reset || kick) begin
      rs <= RSP_INI; A <= '0; rb <= '0; rflag <= 1'b0;
    end else begin
      case (rs)
        RSP_INI: if (Start) begin A <= Ain; rb <= Bin; rflag <= 1'b0; rs <= RSP_ADJ; end
        RSP_ADJ: if (!stall) begin
          if (A == rb) rs <= RSP_DONE;
          else if (A < rb && !rflag) A <= A + 12'd100;
          else if (A > rb) begin A <= A - 12'd10; rflag <= 1'b1; end
          else rs <= RSP_DONE;
        end
        RSP_DONE: if (Ack) rs <= RSP_INI;
        default: rs <= RSP_INI;
      endcase
    end
  end

  typedef struct { logic [W-1:0] a; logic [W-1:0] b; } job_t;
  typedef struct { logic [W-1:0] a; logic [W-1:0] b; logic [W-1:0] exp; } vec_t;

  job_t q[$];
  int   total = 0, bad = 0;
  int   starts = 0, results = 0, cyc = 0, last_start_cyc = 0;
  logic prev_err = 1'b0;

  function automatic int exp_k(input int a, input int b);
    return (a < b) ? (b - a + 99) / 100 : 0;
  endfunction

  function automatic int exp_m(input int a, input int b);
    int x;
    x = a + 100 * exp_k(a, b);
    return (x > b) ? (x - b + 9) / 10 : 0;
  endfunction

  function automatic int exp_res(input int a, input int b);
    return a + 100 * exp_k(a, b) - 10 * exp_m(a, b);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock; updates the queue model from what the host did and what the DUT reports
  task automatic tick();
    logic acc, rst_was;
    job_t j, h;
    acc = Req && Rdy && Reset;
    rst_was = !Reset;
    j.a = Ain_in; j.b = Bin_in;
    @(posedge Clk); #1;
    cyc++;
    if (rst_was) begin
      q.delete();
    end else begin
      if (acc) q.push_back(j);
      if (Start) begin starts++; last_start_cyc = cyc; end
      if (Result_valid) begin
        results++;
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL result_without_job: got %0d expected none", Result);
        end else begin
          h = q.pop_front();
          chk("result", 32'(Result), 32'(exp_res(int'(h.a), int'(h.b))));
        end
      end
      if (Err && !prev_err && q.size() > 0) h = q.pop_front();
      chk("rdy", 32'(Rdy), 32'(q.size() < DEPTH));
    end
    prev_err = Err;
  endtask

  task automatic push(input int a, input int b);
    Req = 1'b1; Ain_in = W'(a); Bin_in = W'(b);
    tick();
    Req = 1'b0;
  endtask

  task automatic wait_result(input string name, input int budget, output logic ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      tick();
      if (Result_valid) begin ok = 1'b1; break; end
    end
    if (!ok) chk({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[6];
    logic ok;
    int   s0, r0, ecyc;
    logic [W-1:0] got[4];

    tbl[0] = '{12'd50,   12'd300,  12'd300};
    tbl[1] = '{12'd77,   12'd77,   12'd77};
    tbl[2] = '{12'd300,  12'd50,   12'd50};
    tbl[3] = '{12'd10,   12'd15,   12'd10};
    tbl[4] = '{12'd1000, 12'd1234, 12'd1230};
    tbl[5] = '{12'd0,    12'd0,    12'd0};

    // Reset state
    Reset = 1'b0; tick(); tick(); Reset = 1'b1;
    chk("rst_rdy", 32'(Rdy), 1);
    chk("rst_start", 32'(Start), 0);
    chk("rst_ack", 32'(Ack), 0);
    chk("rst_rv", 32'(Result_valid), 0);
    chk("rst_err", 32'(Err), 0);
    chk("rst_ain", 32'(Ain), 0);
    chk("rst_bin", 32'(Bin), 0);
    chk("rst_result", 32'(Result), 0);

    // Single jobs from the table, with latency and Ack handshake
    for (int i = 0; i < 6; i++) begin
      s0 = starts;
      push(int'(tbl[i].a), int'(tbl[i].b));
      wait_result("tbl", 300, ok);
      if (ok) begin
        chk("tbl_result", 32'(Result), 32'(tbl[i].exp));
        chk("tbl_latency", 32'(cyc - last_start_cyc),
            32'(3 + exp_k(int'(tbl[i].a), int'(tbl[i].b)) + exp_m(int'(tbl[i].a), int'(tbl[i].b))));
        chk("tbl_ack_on_valid", 32'(Ack), 1);
        tick();
        chk("tbl_ack_held", 32'(Ack), 1);
        chk("tbl_qi_back", 32'(Qi), 1);
        tick();
        chk("tbl_ack_drop", 32'(Ack), 0);
        chk("tbl_one_start", 32'(starts - s0), 1);
        chk("tbl_rdy_empty", 32'(Rdy), 1);
      end
    end

    // Five back-to-back pushes with the responder stalled: the fifth is dropped
    stall = 1'b1;
    r0 = results;
    for (int i = 0; i < 5; i++) begin
      Req = 1'b1; Ain_in = tbl[i].a; Bin_in = tbl[i].b;
      tick();
      if (i == 3) chk("full_rdy_low", 32'(Rdy), 0);
    end
    Req = 1'b0;
    repeat (4) tick();
    stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_result("full", 300, ok);
      got[i] = Result;
    end
    for (int i = 0; i < 4; i++) chk("full_order", 32'(got[i]), 32'(tbl[i].exp));
    repeat (40) tick();
    chk("full_no_fifth", 32'(results - r0), 4);

    // Timeout: responder frozen in ADJ
    stall = 1'b1;
    push(200, 700);
    push(60, 60);
    ecyc = -1;
    for (int n = 0; n < 400; n++) begin
      tick();
      if (Err) begin ecyc = cyc; break; end
    end
    chk("tmo_err_set", 32'(Err), 1);
    chk("tmo_latency", 32'(ecyc - last_start_cyc), 257);
    chk("tmo_ain_hold", 32'(Ain), 200);
    chk("tmo_bin_hold", 32'(Bin), 700);
    stall = 1'b0; kick = 1'b1; tick(); kick = 1'b0;
    s0 = starts;
    push(5, 5);
    repeat (10) tick();
    chk("err_no_start", 32'(starts - s0), 0);
    chk("err_sticky", 32'(Err), 1);
    Clear = 1'b1; tick(); Clear = 1'b0;
    chk("err_cleared", 32'(Err), 0);
    wait_result("clr1", 300, ok);
    chk("clr_first", 32'(Result), 60);
    wait_result("clr2", 300, ok);
    chk("clr_second", 32'(Result), 5);
    repeat (3) tick();

    // Reset mid-WAIT flushes queue and job in flight
    stall = 1'b1;
    push(100, 900); push(30, 30); push(40, 40);
    repeat (5) tick();
    Reset = 1'b0; tick(); Reset = 1'b1;
    chk("mrst_start", 32'(Start), 0);
    chk("mrst_ack", 32'(Ack), 0);
    chk("mrst_rv", 32'(Result_valid), 0);
    chk("mrst_err", 32'(Err), 0);
    chk("mrst_rdy", 32'(Rdy), 1);
    chk("mrst_result", 32'(Result), 0);
    chk("mrst_ain", 32'(Ain), 0);
    stall = 1'b0;
    s0 = starts; r0 = results;
    repeat (15) tick();
    chk("mrst_flushed_starts", 32'(starts - s0), 0);
    chk("mrst_flushed_results", 32'(results - r0), 0);

    // Random traffic against the queue model
    s0 = starts; r0 = results;
    begin
      int stall_cnt;
      stall_cnt = 0;
      for (int n = 0; n < 600; n++) begin
        Req    = ($urandom_range(0, 2) == 0);
        Ain_in = W'($urandom_range(0, 1500));
        Bin_in = W'($urandom_range(0, 1500));
        if (stall_cnt > 0) stall_cnt--;
        else if ($urandom_range(0, 15) == 0) stall_cnt = $urandom_range(1, 5);
        stall = (stall_cnt > 0);
        tick();
      end
    end
    Req = 1'b0; stall = 1'b0;
    for (int n = 0; n < 2000 && q.size() > 0; n++) tick();
    repeat (5) tick();
    chk("rand_drained", 32'(q.size()), 0);
    chk("rand_starts_match", 32'(starts - s0), 32'(results - r0));
    chk("rand_no_err", 32'(Err), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ttt_job_driver.md
TTT_JOB_DRIVER -- requirements
Module: ttt_job_driver

Interface
REQ-001 Parameter W, default 12: operand and result width.
REQ-002 Parameter DEPTH, default 4: job queue entries, power of two.
REQ-003 Parameter TIMEOUT, default 255: maximum cycles spent in WAIT.
REQ-004 Clk  in  1  single clock, rising-edge.
REQ-005 Reset  in  1  synchronous, active-low reset.
REQ-006 Req  in  1  host push strobe; a job is accepted when Req=1 and Rdy=1.
REQ-007 Ain_in, Bin_in  in  W  host operands, sampled on push.
REQ-008 Rdy  out  1  queue not full.
REQ-009 Clear  in  1  clears the Err state.
REQ-010 Result  out  W  last captured responder result.
REQ-011 Result_valid  out  1  one-cycle pulse when Result updates.
REQ-012 Err  out  1  sticky timeout flag.
REQ-013 Start, Ack  out  1  handshake to the iterative responder.
REQ-014 Ain, Bin  out  W  operands to the responder, registered.
REQ-015 Qi, Qc, Qd  in  1  one-hot responder state (INI/ADJ/DONE).
REQ-016 A  in  W  responder result, valid while Qd=1.

Function
REQ-017 The block SHALL implement a FIFO of DEPTH jobs {Ain_in, Bin_in}, with wrap-around pointers modulo DEPTH.
REQ-018 The block SHALL drive Rdy = !full; a push when full SHALL be ignored, with no state change.
REQ-019 A simultaneous push and pop SHALL leave the count unchanged, and both SHALL take effect.
REQ-020 The FSM SHALL have the states IDLE, LAUNCH, WAIT, ACK and ERR, one-hot encoded.
REQ-021 IDLE: Start=0, Ack=0; the FSM SHALL go to LAUNCH when the FIFO is not empty and Qi=1.
REQ-022 On the IDLE->LAUNCH edge, the block SHALL load Ain/Bin from the FIFO head and SHALL NOT pop.
REQ-023 LAUNCH: Start=1 for exactly one cycle, then the FSM SHALL go to WAIT unconditionally.
REQ-024 Ain/Bin SHALL remain stable from LAUNCH until the FSM leaves WAIT.
REQ-025 WAIT: the 8-bit timer SHALL count from 0 each cycle; when Qd=1, the block SHALL capture A into Result, pulse Result_valid, pop the head and go to ACK.
REQ-026 When the timer equals TIMEOUT and Qd=0, the block SHALL set Err, pop the head (job discarded) and go to ERR.
REQ-027 If Qd=1 and the timer equals TIMEOUT in the same cycle, the completion SHALL win.
REQ-028 ACK: Ack=1 SHALL be held until Qi=1 is sampled; the FSM SHALL then go to IDLE with Ack deasserted.
REQ-029 ERR: Start=0, Ack=0, no launches; the queue SHALL keep accepting pushes; on Clear=1 the block SHALL clear Err and go to IDLE.
REQ-030 The round-trip latency from LAUNCH to Result_valid SHALL be the responder's DONE time plus 1 cycle.
REQ-031 All outputs SHALL be registered; the block SHALL perform no arithmetic on operands.

Reset
REQ-032 With Reset=0 at a Clk edge, the block SHALL apply: state=IDLE, FIFO empty, Rdy=1, Start=0, Ack=0, Ain=Bin=0, Result=0, Result_valid=0, Err=0, timer=0.
REQ-033 A reset during LAUNCH, WAIT or ACK SHALL abandon the job in flight and flush the queue.

Structure
REQ-034 Package ttt_pkg SHALL hold W, the state encodings (the responder's INI/ADJ/DONE and the driver's states) and the default TIMEOUT.
REQ-035 The queue SHALL be the sub-module ttt_job_fifo (push/pop/full/empty/head); the FSM and timer SHALL be top-level.

Verification (the bench uses a behavioural responder: INI/ADJ/DONE, +100 while A<B with flag clear, -10 while A>B)
REQ-036 Push (50,300) -> one Start pulse; Result=300, Result_valid for 1 cycle; Ack held until Qi=1.
REQ-037 Push (77,77) -> Result=77 after the first ADJ cycle; queue empty, Rdy=1.
REQ-038 Push 5 jobs in 5 consecutive cycles with the responder stalled -> Rdy=0 after the 4th push; the 5th job is dropped; the 4 results emerge in push order.
REQ-039 Responder held in ADJ (Qd=0) -> Err=1 at timer=255; no further Start; Clear=1 -> IDLE; the next queued job launches.
REQ-040 Reset=0 asserted for 1 cycle mid-WAIT -> Start=0, Ack=0, Result_valid=0, FIFO empty, Err=0 on the next cycle.
